hist_eq_engine: RTL and testbench

Histogram-equalization core that sits directly upstream of the image memory/display path. It reads an 8-bit grayscale source image from a synchronous pixel memory, builds a 256-bin histogram, converts it to a cumulative distribution, and writes the remapped image to the destination memory. The display ROM later selects and shows that destination image as the equalized (NEW) image. The core runs one frame per `start` pulse through a fixed five-phase FSM.

---
 rtl/hist_eq_engine_if.sv | 40 ++++
 rtl/hist_eq_engine.sv | 141 ++++++++++++++
 tb/tb_hist_eq_engine.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hist_eq_engine_if.sv
// Frame control and source/destination pixel memory bus of the equalizer.
// Master side is the engine; slave side is the host/memory environment.
interface hist_eq_engine_if #(
    parameter int NUM_PIX_LOG2 = 16,
    parameter int PIX_W        = 8
);
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    src_rd_en;
    logic [NUM_PIX_LOG2-1:0] src_addr;
    logic [PIX_W-1:0]        src_data;
    logic                    dst_we;
    logic [NUM_PIX_LOG2-1:0] dst_addr;
    logic [PIX_W-1:0]        dst_data;

    modport master (
        input  start,
        input  src_data,
        output busy,
        output done,
        output src_rd_en,
        output src_addr,
        output dst_we,
        output dst_addr,
        output dst_data
    );

    modport slave (
        output start,
        output src_data,
        input  busy,
        input  done,
        input  src_rd_en,
        input  src_addr,
        input  dst_we,
        input  dst_addr,
        input  dst_data
    );
endinterface

// File: rtl/hist_eq_engine.sv
// Histogram equalizer: clear bins, count frame, build CDF LUT, remap frame; 2N+515 cycles start-to-done.
// No backpressure: source memory answers one cycle after a read, destination accepts every write.
module hist_eq_engine #(
    parameter int NUM_PIX_LOG2 = 16,
    parameter int PIX_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    hist_eq_engine_if.master bus
);
    localparam int BINS  = 1 << PIX_W;
    localparam int NPIX  = 1 << NUM_PIX_LOG2;
    localparam int HW    = NUM_PIX_LOG2 + 1;
    localparam int CNT_W = (HW > PIX_W + 1) ? HW : PIX_W + 1;
    localparam int PW    = NUM_PIX_LOG2 + PIX_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_CDF   = 3'd3;
    localparam logic [2:0] S_MAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]              r_state;
    logic                    r_accept;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_rd_vld;
    logic [NUM_PIX_LOG2-1:0] r_rd_addr;
    logic [HW-1:0]           r_cdf;
    logic [HW-1:0]           r_hist [BINS];
    logic [PIX_W-1:0]        r_lut  [BINS];

    logic                    w_rd_en;
    logic                    w_last_bin;
    logic                    w_last_pix;
    logic [PIX_W-1:0]        w_bin;
    logic [HW-1:0]           w_cdf_incl;
    logic [PW-1:0]           w_prod;
    logic [PIX_W-1:0]        w_lut_val;
    logic                    w_map_we;

    assign w_rd_en    = ((r_state == S_COUNT) || (r_state == S_MAP)) && (r_cnt < CNT_W'(NPIX));
    assign w_last_bin = (r_cnt == CNT_W'(BINS - 1));
    assign w_last_pix = (r_cnt == CNT_W'(NPIX));
    assign w_bin      = r_cnt[PIX_W-1:0];
    assign w_cdf_incl = r_cdf + r_hist[w_bin];
    // cdf never exceeds N, so the scaled value always lands in 0..2^PIX_W-1
    assign w_prod     = PW'(w_cdf_incl) * PW'(BINS - 1);
    assign w_lut_val  = PIX_W'(w_prod >> NUM_PIX_LOG2);
    assign w_map_we   = (r_state == S_MAP) && r_rd_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_accept  <= 1'b0;
            r_cnt     <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_addr <= '0;
            r_cdf     <= '0;
        end else begin
            r_rd_vld <= w_rd_en;
            if (w_rd_en) begin
                r_rd_addr <= r_cnt[NUM_PIX_LOG2-1:0];
            end
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    // start is captured first, the frame begins on the following edge
                    if (r_accept) begin
                        r_accept <= 1'b0;
                        r_state  <= S_CLEAR;
                    end else if (bus.start) begin
                        r_accept <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_cdf <= '0;
                    if (w_last_bin) begin
                        r_cnt   <= '0;
                        r_state <= S_COUNT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_COUNT: begin
                    if (w_last_pix) begin
                        r_cnt   <= '0;
                        r_state <= S_CDF;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CDF: begin
                    r_cdf <= w_cdf_incl;
                    if (w_last_bin) begin
                        r_cnt   <= '0;
                        r_state <= S_MAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MAP: begin
                    if (w_last_pix) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Histogram read is combinational so a repeated pixel sees the previous increment
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_hist[w_bin] <= '0;
        end else if ((r_state == S_COUNT) && r_rd_vld) begin
            r_hist[bus.src_data] <= r_hist[bus.src_data] + HW'(1);
        end
        if (r_state == S_CDF) begin
            r_lut[w_bin] <= w_lut_val;
        end
    end

    assign bus.busy      = (r_state == S_CLEAR) || (r_state == S_COUNT) ||
                           (r_state == S_CDF)   || (r_state == S_MAP);
    assign bus.done      = (r_state == S_DONE);
    assign bus.src_rd_en = w_rd_en;
    assign bus.src_addr  = w_rd_en ? r_cnt[NUM_PIX_LOG2-1:0] : '0;
    assign bus.dst_we    = w_map_we;
    assign bus.dst_addr  = w_map_we ? r_rd_addr : '0;
    assign bus.dst_data  = w_map_we ? r_lut[bus.src_data] : '0;

endmodule

// File: tb/tb_hist_eq_engine.sv
// Directed frames against a cumulative-count model of histogram equalization, 16-pixel frames.
module tb_hist_eq_engine;
    localparam int L   = 4;
    localparam int N   = 1 << L;
    localparam int LAT = 2 * N + 515;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hist_eq_engine_if #(.NUM_PIX_LOG2(L), .PIX_W(8)) bus ();

    hist_eq_engine #(.NUM_PIX_LOG2(L), .PIX_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] src_mem [N];
    logic [7:0] dst_img [N];
    int  cyc       = 0;
    int  start_cyc = 0;
    int  n_cmp     = 0;
    int  n_bad     = 0;
    int  wcnt      = 0;
    int  dcnt      = 0;
    bit  chk_en    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.src_rd_en) bus.src_data <= src_mem[bus.src_addr];
    end

    // Equalized value: fraction of pixels at or below v, scaled to 0..255
    function automatic int model(input int v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) if (int'(src_mem[i]) <= v) c++;
        return (c * 255) >> L;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", name, cyc - start_cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int t;
            bit rd_exp;
            bit we_exp;
            t      = cyc - start_cyc;
            rd_exp = (t >= 257 && t < 257 + N) || (t >= 514 + N && t < 514 + 2 * N);
            we_exp = (t >= 515 + N && t < 515 + 2 * N);
            check("busy", 32'(bus.busy), 32'(t >= 1 && t < LAT));
            check("done", 32'(bus.done), 32'(t == LAT));
            check("src_rd_en", 32'(bus.src_rd_en), 32'(rd_exp));
            if (rd_exp)
                check("src_addr", 32'(bus.src_addr), 32'((t < 514 + N) ? t - 257 : t - 514 - N));
            check("dst_we", 32'(bus.dst_we), 32'(we_exp));
            if (we_exp) begin
                check("dst_addr", 32'(bus.dst_addr), 32'(t - 515 - N));
                check("dst_data", 32'(bus.dst_data), 32'(model(int'(src_mem[t - 515 - N]))));
            end
            if (bus.dst_we) begin
                wcnt++;
                dst_img[bus.dst_addr] = bus.dst_data;
            end
            if (bus.done) dcnt++;
        end
    end

    task automatic zero_check(input string tag);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_src_rd_en"}, 32'(bus.src_rd_en), 32'd0);
        check({tag, "_src_addr"},  32'(bus.src_addr),  32'd0);
        check({tag, "_dst_we"},    32'(bus.dst_we),    32'd0);
        check({tag, "_dst_addr"},  32'(bus.dst_addr),  32'd0);
        check({tag, "_dst_data"},  32'(bus.dst_data),  32'd0);
    endtask

    task automatic run_frame(input bit repulse, input int abort_t);
        wcnt = 0;
        dcnt = 0;
        @(negedge clk);
        start_cyc = cyc + 1;
        bus.start = 1'b1;
        chk_en    = 1'b1;
        for (int k = 0; k < LAT + 6; k++) begin
            @(negedge clk);
            bus.start = repulse && (k == 260 || k == 535);
            if (k == abort_t) begin
                #2 rst_n = 1'b0;
                chk_en = 1'b0;
                #1 zero_check("abort");
                repeat (3) @(negedge clk);
                zero_check("held");
                rst_n = 1'b1;
                return;
            end
        end
        chk_en = 1'b0;
        check("write_count", 32'(wcnt), 32'(N));
        check("done_count",  32'(dcnt), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        #3 zero_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N; i++) src_mem[i] = 8'd10;
        run_frame(1'b0, -1);
        check("flat_px0",  32'(dst_img[0]),  32'd255);
        check("flat_px15", 32'(dst_img[15]), 32'd255);

        for (int i = 0; i < N; i++) src_mem[i] = (i < 8) ? 8'd0 : 8'd200;
        run_frame(1'b0, -1);
        check("split_px0",  32'(dst_img[0]),  32'd127);
        check("split_px15", 32'(dst_img[15]), 32'd255);

        for (int i = 0; i < N; i++) src_mem[i] = 8'(i);
        run_frame(1'b0, -1);
        check("ramp_px0",  32'(dst_img[0]),  32'd15);
        check("ramp_px7",  32'(dst_img[7]),  32'd127);
        check("ramp_px15", 32'(dst_img[15]), 32'd255);

        for (int i = 0; i < N; i++) src_mem[i] = ((i % 4) == 3) ? 8'd9 : 8'd5;
        run_frame(1'b1, -1);
        check("rep_px0", 32'(dst_img[0]), 32'd191);
        check("rep_px3", 32'(dst_img[3]), 32'd255);
        check("rep_px4", 32'(dst_img[4]), 32'd191);

        for (int i = 0; i < N; i++) src_mem[i] = 8'(i);
        run_frame(1'b0, 536);
        for (int i = 0; i < N; i++) dst_img[i] = 8'hxx;
        run_frame(1'b0, -1);
        check("post_rst_px0",  32'(dst_img[0]),  32'd15);
        check("post_rst_px7",  32'(dst_img[7]),  32'd127);
        check("post_rst_px15", 32'(dst_img[15]), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
